// File: rtl/cpu_pkg.sv
// Shared constants and state encoding for the CPU stage sequencer.
package cpu_pkg;

  localparam int STATE_W      = 3;
  localparam int WAIT_MAX_DEF = 16;
  localparam int CNT_W_DEF    = 32;

  // Encoding is visible on state_o, so the values are fixed.
  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 3'b000,
    ST_FETCH   = 3'b001,
    ST_DECODE  = 3'b010,
    ST_EXECUTE = 3'b011,
    ST_MEMORY  = 3'b100,
    ST_WRITE   = 3'b101,
    ST_FAULT   = 3'b110,
    ST_HALT    = 3'b111
  } state_e;

endpackage

// File: rtl/stage_wait_timer.sv
// Wait-cycle counter shared by FETCH and MEMORY; flags the last allowed wait cycle.
module stage_wait_timer #(
  parameter int WAIT_MAX = 16,
  parameter int WAIT_W   = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic limit_o
);

  localparam int LIM = (WAIT_MAX > 0) ? WAIT_MAX - 1 : 0;

  logic [WAIT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + WAIT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // WAIT_MAX of zero disables the timeout entirely.
  assign limit_o = (WAIT_MAX > 0) && (cnt_q == WAIT_W'(LIM));

endmodule

// File: rtl/cpu_stage_sequencer.sv
// Multicycle fetch/decode/execute/memory/write sequencer with wait handshakes and timeout fault.
// Optional cycle/retire counters are built when CPU_PERF_COUNTERS_EN is defined.
//
// state   | meaning
// HALT    | stopped, waiting for run
// IDLE    | one-cycle start-up before the first fetch
// FETCH   | instruction memory read, waits for imem_ready
// DECODE  | one-cycle decode
// EXECUTE | ALU / register-file read, picks MEMORY or WRITE
// MEMORY  | data memory access, waits for dmem_ready
// WRITE   | write-back and pc update, retires the instruction
// FAULT   | wait timeout, left only through rst
module cpu_stage_sequencer
  import cpu_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEF,
  parameter int WAIT_MAX = WAIT_MAX_DEF,
  parameter int WAIT_W   = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic               halt_req,
  input  logic               imem_ready,
  input  logic               dmem_ready,
  input  logic               mem_op,
  input  logic               reg_write_req,
  output logic               if_en,
  output logic               id_en,
  output logic               ex_en,
  output logic               mem_en,
  output logic               wb_en,
  output logic               pc_we,
  output logic               retire,
  output logic               fault,
  output logic [STATE_W-1:0] state_o,
  output logic [CNT_W-1:0]   cycle_cnt,
  output logic [CNT_W-1:0]   instret_cnt
);

  state_e state_q, state_d;
  logic   wait_clr, wait_en, wait_limit;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_HALT:    if (run) state_d = ST_IDLE;
      ST_IDLE:    state_d = ST_FETCH;
      ST_FETCH: begin
        if (imem_ready)      state_d = ST_DECODE;
        else if (wait_limit) state_d = ST_FAULT;
      end
      ST_DECODE:  state_d = ST_EXECUTE;
      ST_EXECUTE: state_d = mem_op ? ST_MEMORY : ST_WRITE;
      ST_MEMORY: begin
        if (dmem_ready)      state_d = ST_WRITE;
        else if (wait_limit) state_d = ST_FAULT;
      end
      ST_WRITE:   state_d = halt_req ? ST_HALT : ST_FETCH;
      ST_FAULT:   state_d = ST_FAULT;
      default:    state_d = ST_HALT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_HALT;
    end else begin
      state_q <= state_d;
    end
  end

  // Ready in the limit cycle already steered state_d away from FAULT above.
  assign wait_clr = (state_d != state_q);
  assign wait_en  = ((state_q == ST_FETCH)  && !imem_ready) ||
                    ((state_q == ST_MEMORY) && !dmem_ready);

  stage_wait_timer #(
    .WAIT_MAX (WAIT_MAX),
    .WAIT_W   (WAIT_W)
  ) u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (wait_clr),
    .en_i    (wait_en),
    .limit_o (wait_limit)
  );

  assign if_en   = (state_q == ST_FETCH);
  assign id_en   = (state_q == ST_DECODE);
  assign ex_en   = (state_q == ST_EXECUTE);
  assign mem_en  = (state_q == ST_MEMORY);
  assign wb_en   = (state_q == ST_WRITE) && reg_write_req;
  assign pc_we   = (state_q == ST_WRITE);
  assign retire  = (state_q == ST_WRITE);
  assign fault   = (state_q == ST_FAULT);
  assign state_o = state_q;

`ifdef CPU_PERF_COUNTERS_EN
  logic [CNT_W-1:0] cycle_q, cycle_d;
  logic [CNT_W-1:0] instret_q, instret_d;

  always_comb begin
    cycle_d   = cycle_q;
    instret_d = instret_q;
    if ((state_q != ST_HALT) && (state_q != ST_FAULT)) begin
      cycle_d = cycle_q + CNT_W'(1);
    end
    if (retire) begin
      instret_d = instret_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      cycle_q   <= cycle_d;
      instret_q <= instret_d;
    end
  end

  assign cycle_cnt   = cycle_q;
  assign instret_cnt = instret_q;
`else
  assign cycle_cnt   = '0;
  assign instret_cnt = '0;
`endif

endmodule

// File: tb/tb_cpu_stage_sequencer.sv
// Scoreboard bench for cpu_stage_sequencer: per-cycle stimulus and expected state are queued and
// compared as the DUT steps through them.
module tb_cpu_stage_sequencer;

  localparam int CNT_W    = 4;
  localparam int WAIT_MAX = 4;
  localparam int WAIT_W   = 3;

  localparam logic [2:0] S_IDLE = 3'b000, S_FETCH = 3'b001, S_DECODE = 3'b010,
                         S_EXEC = 3'b011, S_MEM   = 3'b100, S_WRITE  = 3'b101,
                         S_FAULT = 3'b110, S_HALT = 3'b111;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic run = 1'b0, halt_req = 1'b0, imem_ready = 1'b0, dmem_ready = 1'b0;
  logic mem_op = 1'b0, reg_write_req = 1'b0;
  logic if_en, id_en, ex_en, mem_en, wb_en, pc_we, retire, fault;
  logic [2:0] state_o;
  logic [CNT_W-1:0] cycle_cnt, instret_cnt;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic [2:0] st;
    logic run, im, dm, mop, h, rw;
  } entry_t;

  entry_t sb_q[$];

  cpu_stage_sequencer #(
    .CNT_W    (CNT_W),
    .WAIT_MAX (WAIT_MAX),
    .WAIT_W   (WAIT_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .run           (run),
    .halt_req      (halt_req),
    .imem_ready    (imem_ready),
    .dmem_ready    (dmem_ready),
    .mem_op        (mem_op),
    .reg_write_req (reg_write_req),
    .if_en         (if_en),
    .id_en         (id_en),
    .ex_en         (ex_en),
    .mem_en        (mem_en),
    .wb_en         (wb_en),
    .pc_we         (pc_we),
    .retire        (retire),
    .fault         (fault),
    .state_o       (state_o),
    .cycle_cnt     (cycle_cnt),
    .instret_cnt   (instret_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void push(input logic [2:0] st, input logic r, input logic im,
                               input logic dm, input logic mop, input logic h, input logic rw);
    entry_t e;
    e.st = st; e.run = r; e.im = im; e.dm = dm; e.mop = mop; e.h = h; e.rw = rw;
    sb_q.push_back(e);
  endfunction

  function automatic logic [10:0] exp_vec(input entry_t e);
    return {e.st, e.st == S_FETCH, e.st == S_DECODE, e.st == S_EXEC, e.st == S_MEM,
            (e.st == S_WRITE) && e.rw, e.st == S_WRITE, e.st == S_WRITE, e.st == S_FAULT};
  endfunction

  function automatic logic [10:0] obs_vec();
    return {state_o, if_en, id_en, ex_en, mem_en, wb_en, pc_we, retire, fault};
  endfunction

  // Drains the scoreboard: each entry drives one cycle of inputs and is compared in that cycle.
  task automatic run_seq(input string name);
    int cyc = 0;
    entry_t e;
    while (sb_q.size() > 0) begin
      @(negedge clk);
      e = sb_q.pop_front();
      run = e.run; imem_ready = e.im; dmem_ready = e.dm;
      mem_op = e.mop; halt_req = e.h; reg_write_req = e.rw;
      #1;
      check($sformatf("%s[%0d]", name, cyc), 32'(obs_vec()), 32'(exp_vec(e)));
      cyc++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    run = 1'b0; halt_req = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
    mem_op = 1'b0; reg_write_req = 1'b0;
    #1;
    check("reset_state", 32'(obs_vec()), {21'd0, S_HALT, 8'd0});
    check("reset_cycle_cnt", 32'(cycle_cnt), 32'd0);
    check("reset_instret_cnt", 32'(instret_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    do_reset();

    // Non-memory instruction, then memory instruction with 3 waits (ready lands on limit cycle).
    push(S_HALT, 1, 0, 0, 0, 0, 0);
    push(S_IDLE, 1, 0, 0, 0, 0, 0);
    push(S_FETCH, 1, 1, 0, 0, 0, 1);
    push(S_DECODE, 1, 0, 0, 0, 0, 1);
    push(S_EXEC, 1, 0, 0, 0, 0, 1);
    push(S_WRITE, 1, 0, 0, 0, 0, 1);
    push(S_FETCH, 1, 1, 0, 0, 0, 1);
    push(S_DECODE, 1, 0, 0, 1, 0, 1);
    push(S_EXEC, 1, 0, 0, 1, 0, 1);
    for (int i = 0; i < 3; i++) push(S_MEM, 1, 0, 0, 1, 0, 1);
    push(S_MEM, 1, 0, 1, 1, 0, 1);
    push(S_WRITE, 0, 0, 0, 0, 1, 1);
    push(S_HALT, 0, 1, 1, 1, 1, 1);
    push(S_HALT, 0, 1, 1, 1, 1, 1);
    run_seq("basic");

    // halt_req held from DECODE stops after WRITE; dropped before WRITE keeps fetching.
    push(S_HALT, 1, 0, 0, 0, 0, 0);
    push(S_IDLE, 1, 0, 0, 0, 0, 0);
    push(S_FETCH, 1, 0, 0, 0, 0, 0);
    push(S_FETCH, 1, 1, 0, 0, 0, 0);
    push(S_DECODE, 1, 0, 0, 0, 1, 0);
    push(S_EXEC, 1, 0, 0, 0, 1, 0);
    push(S_WRITE, 0, 0, 0, 0, 1, 0);
    push(S_HALT, 0, 0, 0, 0, 0, 0);
    push(S_HALT, 1, 0, 0, 0, 0, 0);
    push(S_IDLE, 1, 0, 0, 0, 0, 0);
    push(S_FETCH, 1, 1, 0, 0, 0, 1);
    push(S_DECODE, 1, 0, 0, 0, 1, 1);
    push(S_EXEC, 1, 0, 0, 0, 0, 1);
    push(S_WRITE, 1, 0, 0, 0, 0, 1);
    // Fetch timeout: 4 FETCH cycles with imem_ready low, then sticky FAULT.
    for (int i = 0; i < 4; i++) push(S_FETCH, 1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) push(S_FAULT, 1, 1, 1, 1, 0, 1);
    run_seq("halt_fault");
    do_reset();

    // Asynchronous reset in the middle of a MEMORY wait.
    push(S_HALT, 1, 0, 0, 0, 0, 1);
    push(S_IDLE, 1, 0, 0, 0, 0, 1);
    push(S_FETCH, 1, 1, 0, 0, 0, 1);
    push(S_DECODE, 1, 0, 0, 1, 0, 1);
    push(S_EXEC, 1, 0, 0, 1, 0, 1);
    push(S_MEM, 1, 0, 0, 1, 0, 1);
    run_seq("mid_mem");
    #1 rst = 1'b1;
    #1 check("mid_mem_async_rst", 32'(obs_vec()), {21'd0, S_HALT, 8'd0});
    do_reset();

    // 20 non-memory instructions: 1 IDLE + 80 active cycles.
    push(S_HALT, 1, 0, 0, 0, 0, 1);
    push(S_IDLE, 1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 20; i++) begin
      push(S_FETCH, 1, 1, 0, 0, 0, 1);
      push(S_DECODE, 1, 0, 0, 0, 0, 1);
      push(S_EXEC, 1, 0, 0, 0, 0, 1);
      push(S_WRITE, 0, 0, 0, 0, (i == 19), 1);
    end
    for (int i = 0; i < 3; i++) push(S_HALT, 0, 1, 1, 1, 1, 1);
`ifdef CPU_PERF_COUNTERS_EN
    run_seq("perf");
    check("instret_wrap", 32'(instret_cnt), 32'(20 % 16));
    check("cycle_wrap", 32'(cycle_cnt), 32'(81 % 16));
    repeat (4) @(negedge clk);
    #1;
    check("cycle_frozen_halt", 32'(cycle_cnt), 32'(81 % 16));
    check("instret_frozen_halt", 32'(instret_cnt), 32'(20 % 16));
`else
    run_seq("perf");
    check("instret_tied0", 32'(instret_cnt), 32'd0);
    check("cycle_tied0", 32'(cycle_cnt), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/cpu_stage_sequencer.md
Name: cpu_stage_sequencer

Overview:
- Parametrised multicycle stage sequencer for the RISC-V core. It replaces the fixed free-running fetch/decode/execute/memory/write state machine.
- Adds memory ready/wait handshakes, a skip of the memory stage for non-memory instructions, and a halt request.
- Adds a wait-timeout fault and optional cycle/retire counters.
- Sits between the control decoder and the datapath enables (pc, instr_mem, register_file, data_mem).

Parameters:
- CNT_W, 32, width of the performance counters.
- WAIT_MAX, 16, maximum wait cycles in FETCH or MEMORY before a FAULT. 0 disables the timeout.
- WAIT_W, 5, width of the wait counter. Must satisfy 2^WAIT_W > WAIT_MAX.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- run  in  1  leave HALT when high.
- halt_req  in  1  stop after the current instruction retires.
- imem_ready  in  1  instruction memory data valid.
- dmem_ready  in  1  data memory access complete.
- mem_op  in  1  decoded instruction is a load or store; valid from DECODE onward.
- reg_write_req  in  1  decoded instruction writes rd.
- if_en  out  1  fetch enable (instr_mem read).
- id_en  out  1  decode enable.
- ex_en  out  1  execute / register-file read enable.
- mem_en  out  1  data memory enable.
- wb_en  out  1  register write enable.
- pc_we  out  1  program counter update strobe.
- retire  out  1  one-cycle pulse per completed instruction.
- fault  out  1  sticky wait-timeout fault.
- state_o  out  3  current state encoding.
- cycle_cnt  out  CNT_W  cycle counter.
- instret_cnt  out  CNT_W  retired-instruction counter.

Behaviour:
- State encoding: HALT=111, IDLE=000, FETCH=001, DECODE=010, EXECUTE=011, MEMORY=100, WRITE=101, FAULT=110.
- Reset values: state=HALT, wait counter=0, counters=0, all outputs 0 except state_o=111.
- Outputs are Moore, decoded from the registered state:
  - if_en=FETCH, id_en=DECODE, ex_en=EXECUTE, mem_en=MEMORY.
  - wb_en=WRITE & reg_write_req.
  - pc_we=retire=WRITE.
  - fault=FAULT.
- Transitions:
  - HALT: to IDLE when run=1, else stay.
  - IDLE: to FETCH unconditionally.
  - FETCH: if_en held high. imem_ready=1 goes to DECODE. Otherwise the wait counter increments.
  - DECODE: to EXECUTE after exactly 1 cycle.
  - EXECUTE: to MEMORY if mem_op=1, else to WRITE.
  - MEMORY: mem_en held high. dmem_ready=1 goes to WRITE. Otherwise the wait counter increments.
  - WRITE: 1 cycle. Goes to HALT if halt_req=1, else to FETCH.
  - FAULT: terminal; exited only by rst.
- Wait counter:
  - Cleared on every state change.
  - With WAIT_MAX>0, reaching WAIT_MAX-1 with ready still low goes to FAULT on the next edge.
  - Ready arriving in the same cycle as the limit wins; no fault.
- halt_req is sampled only in WRITE. An in-flight instruction always completes; there is no mid-instruction halt.
- Latency: a non-memory instruction with zero waits takes 4 cycles (FETCH-DECODE-EXECUTE-WRITE). A memory instruction takes 5 + waits.
- Asynchronous rst in any state, including mid-MEMORY, forces HALT immediately. No partial write-back completes: wb_en drops with the state.
- Inputs other than run are ignored in HALT and FAULT.

Optional Feature:
- Macro: CPU_PERF_COUNTERS_EN.
- When defined:
  - cycle_cnt increments every cycle the state is not HALT or FAULT.
  - instret_cnt increments on retire.
  - Both wrap modulo 2^CNT_W with no saturation.
- When undefined: counter registers are not built and both outputs are tied to 0.

Decomposition:
- Shared package cpu_pkg holds:
  - the 3-bit state localparams (HALT..FAULT);
  - the default WAIT_MAX and CNT_W constants;
  - the state width constant.
- One natural sub-module, stage_wait_timer: a loadable wait counter with clear, enable and limit-reached output. It is instanced once and shared by FETCH and MEMORY.

Test Plan:
- rst, run=1, imem_ready=1, mem_op=0, reg_write_req=1 -> state_o sequence 111,000,001,010,011,101,001. wb_en and retire high for one cycle in WRITE.
- mem_op=1, dmem_ready held low 3 cycles then high -> mem_en high 4 cycles, then WRITE. Memory-instruction latency 8 cycles. No fault.
- WAIT_MAX=4, imem_ready stuck 0 -> FAULT (110) entered after 4 FETCH cycles, fault=1, sticky. rst returns the sequencer to HALT.
- halt_req=1 asserted during DECODE and held -> instruction finishes, retire pulses once, next state HALT. Deasserting halt_req before WRITE -> FETCH.
- rst asserted mid-MEMORY -> state_o=111 and all enables 0 immediately, before the next clock edge.
- CPU_PERF_COUNTERS_EN with CNT_W=4, 20 non-memory instructions -> instret_cnt=20 mod 16=4. cycle_cnt wraps; it is frozen while halted.
